pulse_event_scheduler: RTL

//  Shares one event path among N level inputs (buttons/switches) and acts as the

---
 rtl/pulse_event_scheduler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pulse_event_scheduler.sv
// pulse_event_scheduler: synchronises N level inputs, turns each rising edge
// into a pending request, and grants requests round-robin onto a single
// valid/ready event port. Edges arriving on an already-pending channel are
// counted as drops in a saturating counter.
module pulse_event_scheduler #(
    parameter  int N     = 4,
    parameter  int CNT_W = 8,
    localparam int ID_W  = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N-1:0]     L,
    input  logic             ev_ready,
    input  logic             drop_clr,
    output logic             ev_valid,
    output logic [ID_W-1:0]  ev_id,
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      s1_q, s2_q, prev_q;
    logic [N-1:0]      edge_det;
    logic [N-1:0]      pending_q, pending_d;
    logic [N-1:0]      grant_clr;
    logic [N-1:0]      drop_vec;
    logic              any_drop;
    logic [ID_W-1:0]   ev_id_q, ev_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic              grant_found;
    logic [CNT_W-1:0]  drop_cnt_q;

    // Two-flop synchroniser plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= L;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign edge_det = s2_q & ~prev_q;

    // Round-robin search: first pending channel after the last one served.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = ID_W'((32'(last_grant_q) + k) % N);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // FSM next state, grant capture and handshake completion.
    always_comb begin
        state_d      = state_q;
        ev_id_d      = ev_id_q;
        last_grant_d = last_grant_q;
        grant_clr    = '0;
        case (state_q)
            IDLE: begin
                if (en && grant_found) begin
                    ev_id_d              = grant_idx;
                    grant_clr[grant_idx] = 1'b1;
                    state_d              = OFFER;
                end
            end
            OFFER: begin
                if (ev_ready) begin
                    last_grant_d = ev_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new edge on the channel being granted re-arms it rather than dropping.
    always_comb begin
        pending_d = edge_det | (pending_q & ~grant_clr);
        drop_vec  = edge_det & pending_q & ~grant_clr;
        any_drop  = |drop_vec;
    end

    // FSM state, offered id, round-robin pointer and pending flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ev_id_q      <= '0;
            last_grant_q <= ID_W'(N - 1);
            pending_q    <= '0;
        end else begin
            state_q      <= state_d;
            ev_id_q      <= ev_id_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
        end
    end

    // Saturating drop counter; clear wins but still counts a same-cycle drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else if (drop_clr) begin
            drop_cnt_q <= any_drop ? CNT_W'(1) : '0;
        end else if (any_drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign ev_valid = (state_q == OFFER);
    assign ev_id    = ev_id_q;
    assign pending  = pending_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = (state_q == OFFER) | (|pending_q);

endmodule
